// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one Fibonacci LFSR across NREQ requesters.
// Optional macro LFSR_SCHED_FREERUN_EN also advances the LFSR on idle cycles.
module lfsr_sched #(
    parameter int               NREQ  = 4,
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'hA5,
    parameter int               STEPS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ARB, STEP, DELIVER} state_t;

    state_t           st, st_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_adv, rnd_q;
    logic [PW-1:0]    ptr, grantee, pick;
    logic [3:0]       cnt;
    logic [NREQ-1:0]  req_q, cand;
    logic             found;
    int               idx;

    assign lfsr_adv = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};

    // A one-cycle request pulse seen in IDLE is kept so ARB can still serve it.
    assign cand = req | req_q;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (!seed_we && |req) st_nxt = ARB;
            ARB:     st_nxt = found ? STEP : IDLE;
            STEP:    if (cnt == 4'd1) st_nxt = DELIVER;
            DELIVER: st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            lfsr    <= SEED;
            ptr     <= '0;
            grantee <= '0;
            cnt     <= '0;
            req_q   <= '0;
            rnd_q   <= '0;
        end else begin
            st <= st_nxt;
            case (st)
                IDLE: begin
                    req_q <= req;
                    if (seed_we)
                        lfsr <= (seed == '0) ? SEED : seed;
`ifdef LFSR_SCHED_FREERUN_EN
                    else
                        lfsr <= lfsr_adv;
`endif
                end
                ARB: begin
                    grantee <= pick;
                    cnt     <= 4'(STEPS);
                end
                STEP: begin
                    lfsr <= lfsr_adv;
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd1) rnd_q <= lfsr_adv;
                end
                DELIVER: ptr <= (grantee == PW'(NREQ - 1)) ? '0 : grantee + PW'(1);
                default: ;
            endcase
        end
    end

    assign gnt       = (st == DELIVER) ? (NREQ'(1) << grantee) : '0;
    assign rnd_valid = (st == DELIVER);
    assign busy      = (st != IDLE);
    assign rnd       = rnd_q;
endmodule

// File: tb/tb_lfsr_sched.sv
// Bench for lfsr_sched: directed literal checks plus randomized traffic
// checked every cycle against a phase-count reference model.
module tb_lfsr_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int STEPS = 3;
    localparam logic [7:0] SEEDV = 8'hA5;
    localparam logic [7:0] TAPSV = 8'hB8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic             seed_we = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rnd;
    logic             rnd_valid;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    lfsr_sched dut (
        .clk(clk), .rst(rst), .req(req), .seed_we(seed_we), .seed(seed),
        .gnt(gnt), .rnd(rnd), .rnd_valid(rnd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] adv(input logic [7:0] s, input int n);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {v[6:0], ^(v & TAPSV)};
        return v;
    endfunction

    // Model: m_t counts cycles since leaving idle (0 = idle, 1 = arb,
    // 2..STEPS+1 = stepping, STEPS+2 = delivering).
    int         m_t = 0;
    int         m_ptr = 0;
    int         m_gi = 0;
    logic [7:0] m_state = SEEDV;
    logic [7:0] m_rnd = 8'h00;
    logic [3:0] m_cap = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_ptr = 0; m_gi = 0; m_state = SEEDV; m_rnd = 8'h00; m_cap = '0;
        end else if (m_t == 0) begin
            if (seed_we) m_state = (seed == 8'h00) ? SEEDV : seed;
            else begin
`ifdef LFSR_SCHED_FREERUN_EN
                m_state = adv(m_state, 1);
`endif
                if (|req) begin m_cap = req; m_t = 1; end
            end
        end else if (m_t == 1) begin
            logic [3:0] c;
            c = m_cap | req;
            for (int i = NREQ - 1; i >= 0; i--)
                if (c[(m_ptr + i) % NREQ]) m_gi = (m_ptr + i) % NREQ;
            m_state = adv(m_state, STEPS);
            m_t = 2;
        end else if (m_t < STEPS + 1) begin
            m_t++;
        end else if (m_t == STEPS + 1) begin
            m_rnd = m_state;
            m_t++;
        end else begin
            m_ptr = (m_gi + 1) % NREQ;
            m_t = 0;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e_gnt;
        logic       e_vld;
        e_vld = (m_t == STEPS + 2);
        e_gnt = e_vld ? 4'(1 << m_gi) : 4'b0000;
        vectors++;
        if (gnt !== e_gnt || rnd !== m_rnd || rnd_valid !== e_vld || busy !== (m_t != 0)) begin
            miscompares++;
            $display("FAIL model t=%0t gnt=%b/%b rnd=%h/%h vld=%b/%b busy=%b/%b (actual/required)",
                     $time, gnt, e_gnt, rnd, m_rnd, rnd_valid, e_vld, busy, (m_t != 0));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pulse req for one cycle, then land just after the delivering edge.
    task automatic grant(input logic [3:0] r);
        req = r;
        tick();
        req = '0;
        tick(STEPS + 1);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_rnd", 32'(rnd), 32'h00);
        chk("reset_gnt", 32'(gnt), 32'h0);

        grant(4'b0001);
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_vld", 32'(rnd_valid), 32'h1);
        chk("first_rnd", 32'(rnd), 32'h2A);
        tick();
        chk("first_vld_drop", 32'(rnd_valid), 32'h0);
        chk("first_rnd_hold", 32'(rnd), 32'h2A);

        seed_we = 1'b1; seed = 8'h01; tick(); seed_we = 1'b0;
        grant(4'b0100);
        chk("seed01_g1_gnt", 32'(gnt), 32'h4);
        chk("seed01_g1_rnd", 32'(rnd), 32'h08);
        tick();
        grant(4'b0100);
        chk("seed01_g2_rnd", 32'(rnd), 32'h47);
        tick();

        seed_we = 1'b1; seed = 8'h00; tick(); seed_we = 1'b0;
        grant(4'b0001);
        chk("seed00_rnd", 32'(rnd), 32'h2A);
        tick();

        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            logic [3:0] e;
            tick();
            e = (c >= 5 && (c - 5) % 6 == 0) ? 4'(1 << (((c - 5) / 6) % 4)) : 4'b0000;
            chk($sformatf("rr_c%0d", c), 32'(gnt), 32'(e));
        end
        req = '0;
        tick(8);

        req = 4'b0001; tick(); req = '0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_step_gnt", 32'(gnt), 32'h0);
        chk("rst_step_busy", 32'(busy), 32'h0);
        chk("rst_step_rnd", 32'(rnd), 32'h00);
        grant(4'b0001);
        chk("after_rst_rnd", 32'(rnd), 32'h2A);
        tick();

        req = 4'b0001; tick(); req = '0;
        seed_we = 1'b1; seed = 8'h55; tick(); seed_we = 1'b0;
        tick(STEPS);
        chk("busy_seed_rnd", 32'(rnd), 32'h53);
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            seed_we = ($urandom_range(0, 9) == 0);
            seed    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            req     = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            tick();
        end
        rst = 1'b0; seed_we = 1'b0; req = '0;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
